// File: rtl/wb_arbiter_2_pkg.sv
// ---------------------------------------------------------------------------
// arbiter_pkg
// Purpose : shared types and constants for the Wishbone arbiter blocks.
//           Holds the arbitration state enumeration, the reset value of the
//           round-robin pointer and a helper that maps a master index onto
//           its grant state.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package arbiter_pkg;

  // Arbitration states: no owner, or bus owned by master 0 / master 1.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  // last_grant comes out of reset pointing at master 1, so master 0 wins the
  // first contention.
  localparam logic RESET_LAST_GRANT = 1'b1;

  // Grant state belonging to master index idx.
  function automatic arb_state_e grant_state(input logic idx);
    return idx ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/wb_arbiter_2_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_2_if
// Purpose : bundles the two upstream Wishbone master ports and the single
//           downstream slave port of the two-master arbiter.
// Signals : mN_cyc_i/stb_i/we_i/adr_i/dat_i/sel_i  master N request
//           mN_ack_o/dat_o                          response to master N
//           s_cyc_o/stb_o/we_o/adr_o/dat_o/sel_o    request to the slave
//           s_ack_i/dat_i                           slave response
// Modports: slave  - the arbiter's view (it is the slave of the masters and
//                    drives the downstream request).
//           master - the environment's view (masters plus downstream slave),
//                    driving every arbiter input and observing its outputs.
// ---------------------------------------------------------------------------
interface wb_arbiter_2_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  // Master 0
  logic                  m0_cyc_i;
  logic                  m0_stb_i;
  logic                  m0_we_i;
  logic [ADDR_WIDTH-1:0] m0_adr_i;
  logic [DATA_WIDTH-1:0] m0_dat_i;
  logic [SEL_WIDTH-1:0]  m0_sel_i;
  logic                  m0_ack_o;
  logic [DATA_WIDTH-1:0] m0_dat_o;

  // Master 1
  logic                  m1_cyc_i;
  logic                  m1_stb_i;
  logic                  m1_we_i;
  logic [ADDR_WIDTH-1:0] m1_adr_i;
  logic [DATA_WIDTH-1:0] m1_dat_i;
  logic [SEL_WIDTH-1:0]  m1_sel_i;
  logic                  m1_ack_o;
  logic [DATA_WIDTH-1:0] m1_dat_o;

  // Downstream slave
  logic                  s_cyc_o;
  logic                  s_stb_o;
  logic                  s_we_o;
  logic [ADDR_WIDTH-1:0] s_adr_o;
  logic [DATA_WIDTH-1:0] s_dat_o;
  logic [SEL_WIDTH-1:0]  s_sel_o;
  logic                  s_ack_i;
  logic [DATA_WIDTH-1:0] s_dat_i;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    output m0_ack_o, m0_dat_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    output m1_ack_o, m1_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_ack_i, s_dat_i
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    input  m0_ack_o, m0_dat_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    input  m1_ack_o, m1_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_ack_i, s_dat_i
  );

endinterface

// File: rtl/wb_arbiter_2.sv
// ---------------------------------------------------------------------------
// wb_arbiter_2
// Purpose : two-master Wishbone arbiter in front of an SRAM controller slave.
//           A registered FSM (IDLE / GRANT0 / GRANT1) owns the bus decision;
//           the downstream request and the acks are muxed combinationally
//           from the current owner. Contention is resolved round-robin via
//           last_grant, and a grant is held for as long as its master keeps
//           cyc asserted.
// Ports   : clk_i  - sole clock, rising edge
//           rst_i  - synchronous, active-high reset
//           bus    - wb_arbiter_2_if.slave: both master ports plus the
//                    downstream slave port
// ---------------------------------------------------------------------------
module wb_arbiter_2
  import arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  wb_arbiter_2_if.slave bus
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  arb_state_e r_state;
  logic       r_last_grant;

  logic                  w_req0;
  logic                  w_req1;
  logic                  w_s_cyc;
  logic                  w_s_stb;
  logic                  w_s_we;
  logic [ADDR_WIDTH-1:0] w_s_adr;
  logic [DATA_WIDTH-1:0] w_s_dat;
  logic [SEL_WIDTH-1:0]  w_s_sel;
  logic                  w_m0_ack;
  logic                  w_m1_ack;

  // A master requests the bus by raising cyc; stb is only forwarded.
  assign w_req0 = bus.m0_cyc_i;
  assign w_req1 = bus.m1_cyc_i;

  // Arbitration FSM. Leaving a grant always passes through IDLE, which gives
  // the one dead cycle between owners and keeps the first cyc cycle of a new
  // owner from reaching the slave.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_last_grant <= RESET_LAST_GRANT;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req0 && w_req1) begin
            // Contention: hand the bus to whoever did not own it last.
            r_state      <= grant_state(~r_last_grant);
            r_last_grant <= ~r_last_grant;
          end else if (w_req0) begin
            r_state      <= GRANT0;
            r_last_grant <= 1'b0;
          end else if (w_req1) begin
            r_state      <= GRANT1;
            r_last_grant <= 1'b1;
          end
        end
        GRANT0: begin
          if (!w_req0) r_state <= IDLE;
        end
        GRANT1: begin
          if (!w_req1) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output mux. The owner's request passes straight through, so a master
  // dropping cyc mid-transfer drops s_cyc_o in the same cycle. In IDLE
  // everything is driven to zero, which also swallows stray slave acks.
  always_comb begin
    w_s_cyc  = 1'b0;
    w_s_stb  = 1'b0;
    w_s_we   = 1'b0;
    w_s_adr  = '0;
    w_s_dat  = '0;
    w_s_sel  = '0;
    w_m0_ack = 1'b0;
    w_m1_ack = 1'b0;
    case (r_state)
      GRANT0: begin
        w_s_cyc  = bus.m0_cyc_i;
        w_s_stb  = bus.m0_stb_i;
        w_s_we   = bus.m0_we_i;
        w_s_adr  = bus.m0_adr_i;
        w_s_dat  = bus.m0_dat_i;
        w_s_sel  = bus.m0_sel_i;
        w_m0_ack = bus.s_ack_i;
      end
      GRANT1: begin
        w_s_cyc  = bus.m1_cyc_i;
        w_s_stb  = bus.m1_stb_i;
        w_s_we   = bus.m1_we_i;
        w_s_adr  = bus.m1_adr_i;
        w_s_dat  = bus.m1_dat_i;
        w_s_sel  = bus.m1_sel_i;
        w_m1_ack = bus.s_ack_i;
      end
      default: ;
    endcase
  end

  assign bus.s_cyc_o  = w_s_cyc;
  assign bus.s_stb_o  = w_s_stb;
  assign bus.s_we_o   = w_s_we;
  assign bus.s_adr_o  = w_s_adr;
  assign bus.s_dat_o  = w_s_dat;
  assign bus.s_sel_o  = w_s_sel;
  assign bus.m0_ack_o = w_m0_ack;
  assign bus.m1_ack_o = w_m1_ack;

  // Read data is broadcast; only the ack tells a master it is meant for it.
  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;

endmodule

// File: tb/tb_wb_arbiter_2.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter_2
// Drives both masters and the slave response once per clock, predicts the
// arbiter outputs with a transaction-level ownership model (who owns the bus,
// and the history of past grants for round-robin), and checks them in a
// separate monitor that pops the expectation queue every cycle.
// ---------------------------------------------------------------------------
module tb_wb_arbiter_2;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_2_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  wb_arbiter_2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } mreq_t;

  typedef struct packed {
    mreq_t         s;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] mdat;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle_no = 0;

  // Reference model: current bus owner (-1 = nobody) and the list of
  // masters granted since reset, most recent last.
  int owner = -1;
  int served[$];

  // Last observed acks, used only to make the masters react in stimulus.
  logic last_ack0 = 1'b0;
  logic last_ack1 = 1'b0;

  // Round-robin rule: on contention the master that was not served most
  // recently wins; with no history (after reset) master 0 wins.
  function automatic int favored();
    if (served.size() == 0) return 0;
    return (served[served.size()-1] == 1) ? 0 : 1;
  endfunction

  function automatic mreq_t mk(input logic cyc, input logic stb, input logic we,
                               input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                               input logic [SW-1:0] sel);
    mreq_t r;
    r.cyc = cyc; r.stb = stb; r.we = we; r.adr = adr; r.dat = dat; r.sel = sel;
    return r;
  endfunction

  function automatic mreq_t rnd_req(input logic cyc);
    mreq_t r;
    r.cyc = cyc;
    r.stb = cyc ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
    r.we  = 1'($urandom_range(0, 1));
    r.adr = AW'($urandom);
    r.dat = DW'($urandom);
    r.sel = SW'($urandom);
    return r;
  endfunction

  // One clock of stimulus: apply inputs, queue the expected outputs for this
  // cycle, then advance the ownership model to the next cycle.
  task automatic step(input mreq_t r0, input mreq_t r1, input logic ack,
                      input logic [DW-1:0] sdat, input logic rst_v);
    exp_t  e;
    mreq_t req[2];
    @(posedge clk);
    #1;
    rst = rst_v;
    bus.m0_cyc_i = r0.cyc; bus.m0_stb_i = r0.stb; bus.m0_we_i = r0.we;
    bus.m0_adr_i = r0.adr; bus.m0_dat_i = r0.dat; bus.m0_sel_i = r0.sel;
    bus.m1_cyc_i = r1.cyc; bus.m1_stb_i = r1.stb; bus.m1_we_i = r1.we;
    bus.m1_adr_i = r1.adr; bus.m1_dat_i = r1.dat; bus.m1_sel_i = r1.sel;
    bus.s_ack_i  = ack;
    bus.s_dat_i  = sdat;
    req[0] = r0;
    req[1] = r1;

    e      = '0;
    e.mdat = sdat;
    if (owner >= 0) begin
      e.s    = req[owner];
      e.ack0 = (owner == 0) && ack;
      e.ack1 = (owner == 1) && ack;
    end
    exp_q.push_back(e);

    if (rst_v) begin
      owner = -1;
      served.delete();
    end else if (owner >= 0) begin
      if (!req[owner].cyc) owner = -1;
    end else if (r0.cyc || r1.cyc) begin
      owner = (r0.cyc && r1.cyc) ? favored() : (r0.cyc ? 0 : 1);
      served.push_back(owner);
    end
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  always @(negedge clk) begin
    exp_t  e;
    mreq_t act;
    last_ack0 <= bus.m0_ack_o;
    last_ack1 <= bus.m1_ack_o;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = mk(bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o, bus.s_sel_o);
      tests++;
      if (act !== e.s) begin
        fails++;
        $display("FAIL s_bus cyc=%0d got=%h want=%h", cycle_no, act, e.s);
      end
      tests++;
      if (bus.m0_ack_o !== e.ack0) begin
        fails++;
        $display("FAIL m0_ack cyc=%0d got=%b want=%b", cycle_no, bus.m0_ack_o, e.ack0);
      end
      tests++;
      if (bus.m1_ack_o !== e.ack1) begin
        fails++;
        $display("FAIL m1_ack cyc=%0d got=%b want=%b", cycle_no, bus.m1_ack_o, e.ack1);
      end
      tests++;
      if (bus.m0_dat_o !== e.mdat || bus.m1_dat_o !== e.mdat) begin
        fails++;
        $display("FAIL m_dat cyc=%0d got=%h/%h want=%h", cycle_no, bus.m0_dat_o, bus.m1_dat_o, e.mdat);
      end
      $display("[TB] cyc %0d s_cyc=%b adr=%h ack0=%b ack1=%b", cycle_no, bus.s_cyc_o,
               bus.s_adr_o, bus.m0_ack_o, bus.m1_ack_o);
      cycle_no++;
    end
  end

  initial begin
    mreq_t idle_r, a, b;
    mreq_t c0, c1;
    logic  p0, p1;
    idle_r = '0;
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0;
    bus.m0_adr_i = '0; bus.m0_dat_i = '0; bus.m0_sel_i = '0;
    bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0;
    bus.m1_adr_i = '0; bus.m1_dat_i = '0; bus.m1_sel_i = '0;
    bus.s_ack_i = 0; bus.s_dat_i = '0;
    repeat (2) @(posedge clk);

    // Reset state, then a stray slave ack while idle.
    step(idle_r, idle_r, 1'b0, 32'h0, 1'b0);
    step(idle_r, idle_r, 1'b1, 32'h1234_5678, 1'b0);

    // Single master write: mirrored from the second cyc cycle.
    a = mk(1, 1, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    step(a, idle_r, 1'b0, 32'h0, 1'b0);
    step(a, idle_r, 1'b0, 32'h0, 1'b0);
    step(a, idle_r, 1'b1, 32'h0, 1'b0);
    step(idle_r, idle_r, 1'b0, 32'h0, 1'b0);
    step(idle_r, idle_r, 1'b0, 32'h0, 1'b0);

    // Reset so the round-robin history is cleared, then contention.
    step(idle_r, idle_r, 1'b0, 32'h0, 1'b1);
    a = mk(1, 1, 0, 32'h0000_0100, 32'h0, 4'hF);
    b = mk(1, 1, 1, 32'h0000_0200, 32'hCAFE_0001, 4'h3);
    step(a, b, 1'b0, 32'h0, 1'b0);
    step(a, b, 1'b1, 32'hA5A5_0000, 1'b0);
    step(idle_r, b, 1'b0, 32'h0, 1'b0);
    step(idle_r, b, 1'b0, 32'h0, 1'b0);
    step(idle_r, b, 1'b1, 32'h0, 1'b0);
    step(idle_r, idle_r, 1'b0, 32'h0, 1'b0);

    // Fairness: both request continuously, each drops cyc for one cycle
    // after its ack, with the slave acking every granted cycle.
    for (int i = 0; i < 24; i++) begin
      c0 = mk(!last_ack0, 1, 0, 32'h0000_1000 + 32'(i), 32'h0, 4'hF);
      c1 = mk(!last_ack1, 1, 1, 32'h0000_2000 + 32'(i), 32'h1111_0000 + 32'(i), 4'hF);
      step(c0, c1, 1'b1, 32'h5000_0000 + 32'(i), 1'b0);
    end
    step(idle_r, idle_r, 1'b0, 32'h0, 1'b0);
    step(idle_r, idle_r, 1'b0, 32'h0, 1'b0);

    // Hold: m0 does three read beats while m1 waits.
    b = mk(1, 1, 1, 32'h0000_0300, 32'h7777_7777, 4'hF);
    step(mk(1, 1, 0, 32'h0, 32'h0, 4'hF), b, 1'b0, 32'h0, 1'b0);
    for (int beat = 0; beat < 3; beat++) begin
      a = mk(1, 1, 0, 32'(beat * 4), 32'h0, 4'hF);
      step(a, b, 1'b0, 32'h0, 1'b0);
      step(a, b, 1'b1, 32'hB000_0000 + 32'(beat), 1'b0);
    end
    step(idle_r, b, 1'b1, 32'h0, 1'b0);
    step(idle_r, b, 1'b1, 32'h0, 1'b0);
    step(idle_r, idle_r, 1'b0, 32'h0, 1'b0);

    // Reset mid-grant on m1, then contention must grant m0.
    step(idle_r, b, 1'b0, 32'h0, 1'b0);
    step(idle_r, b, 1'b0, 32'h0, 1'b0);
    step(idle_r, b, 1'b1, 32'h0, 1'b1);
    step(idle_r, b, 1'b1, 32'h0, 1'b0);
    a = mk(1, 1, 0, 32'h0000_0400, 32'h0, 4'hF);
    step(a, b, 1'b0, 32'h0, 1'b0);
    step(a, b, 1'b1, 32'h0, 1'b0);
    step(idle_r, idle_r, 1'b0, 32'h0, 1'b0);

    // Random traffic with sticky cyc, random acks and occasional resets.
    p0 = 0;
    p1 = 0;
    for (int i = 0; i < 1500; i++) begin
      p0 = p0 ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
      p1 = p1 ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
      step(rnd_req(p0), rnd_req(p1), 1'($urandom_range(0, 1)), DW'($urandom),
           ($urandom_range(0, 99) == 0));
    end

    // Let the monitor drain, bounded.
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
